cc_miss_req_unit: RTL

Miss request stage of the cache controller, directly upstream of the data fill unit. It accepts one cache miss at a time from the tag-compare stage and issues a critical-word-first AXI WRAP read burst for the 64-byte line on the AR channel. In the acceptance cycle it pushes the miss address into the miss address FIFO, so the fill unit holds the address before the first R beat arrives. It also counts outstanding bursts and throttles new misses to a configurable limit.

---
 rtl/cc_pkg.sv | 22 ++
 rtl/cc_outstanding_counter.sv | 48 ++++
 rtl/cc_miss_req_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/cc_pkg.sv
// ============================================================================
// Module : cc_pkg
// Brief  : Shared cache-controller constants and types for the miss path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cc_pkg;

    localparam int         CC_LINE_BEATS     = 8;
    localparam logic [3:0] CC_AXI_LEN        = 4'd7;
    localparam logic [2:0] CC_AXI_SIZE       = 3'd3;
    localparam logic [1:0] CC_AXI_BURST_WRAP = 2'b10;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        AR_REQ = 1'b1
    } miss_req_state_t;

endpackage

`default_nettype wire

// File: rtl/cc_outstanding_counter.sv
// ============================================================================
// Module : cc_outstanding_counter
// Brief  : Up/down count of line fills in flight with limit compare and
//          sticky underflow flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cc_outstanding_counter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [2:0] o_count,
    output logic       o_at_max,
    output logic       o_err
);

    localparam logic [2:0] c_MAX_CNT = 3'(MAX_OUTSTANDING);

    logic [2:0] r_count;
    logic       r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 3'd0;
            r_err   <= 1'b0;
        end else if (i_inc && !i_dec) begin
            r_count <= r_count + 3'd1;
        end else if (!i_inc && i_dec) begin
            // A completion with nothing in flight is a protocol error; hold at zero.
            if (r_count == 3'd0) begin
                r_err <= 1'b1;
            end else begin
                r_count <= r_count - 3'd1;
            end
        end
    end

    assign o_count  = r_count;
    assign o_at_max = (r_count >= c_MAX_CNT);
    assign o_err    = r_err;

endmodule

`default_nettype wire

// File: rtl/cc_miss_req_unit.sv
// ============================================================================
// Module : cc_miss_req_unit
// Brief  : Accepts one cache miss at a time, pushes its address to the miss
//          address FIFO and issues a critical-word-first AXI WRAP line read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cc_miss_req_unit
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_valid_i,
    input  logic [31:0] miss_addr_i,
    output logic        miss_ready_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    input  logic        mem_rlast_i,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    output logic        busy_o,
    output logic        err_o
);

    miss_req_state_t r_state;
    logic [31:0]     r_araddr;

    logic       w_accept;
    logic       w_push;
    logic       w_rlast;
    logic       w_at_max;
    logic [2:0] w_count;

    assign w_accept = (r_state == IDLE) && !miss_addr_fifo_full_i && !w_at_max;
    assign w_push   = w_accept && miss_valid_i;
    assign w_rlast  = mem_rvalid_i && mem_rready_i && mem_rlast_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_araddr <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        // Beat-aligned address lets the WRAP burst start at the critical word.
                        r_araddr <= {miss_addr_i[31:3], 3'b000};
                        r_state  <= AR_REQ;
                    end
                end
                AR_REQ: begin
                    if (mem_arready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    cc_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_push),
        .i_dec    (w_rlast),
        .o_count  (w_count),
        .o_at_max (w_at_max),
        .o_err    (err_o)
    );

    assign miss_ready_o           = w_accept;
    assign miss_addr_fifo_wren_o  = w_push;
    assign miss_addr_fifo_wdata_o = miss_addr_i;
    assign mem_arvalid_o          = (r_state == AR_REQ);
    assign mem_araddr_o           = r_araddr;
    assign mem_arlen_o            = CC_AXI_LEN;
    assign mem_arsize_o           = CC_AXI_SIZE;
    assign mem_arburst_o          = CC_AXI_BURST_WRAP;
    assign busy_o                 = (w_count != 3'd0) || (r_state == AR_REQ);

endmodule

`default_nettype wire
